stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 123 ++++++++++++
 tb/tb_stack_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// 16 x 8-bit hardware stack with a four-state request/done controller.
// Ports: clk, reset, req, op[1:0], push_data[7:0] in; busy, done, err, tos, nos, count, empty, full out.
module stack_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [7:0] push_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] tos,
  output logic [7:0] nos,
  output logic [4:0] count,
  output logic       empty,
  output logic       full
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    EXEC2,
    DONE
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_POP2 = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  state_t     state;
  logic [7:0] mem [16];
  logic [1:0] op_q;
  logic [7:0] data_q;
  logic       err_q;
  logic [3:0] top_idx;
  logic [3:0] sec_idx;

  assign empty   = (count == 5'd0);
  assign full    = (count == 5'd16);
  assign top_idx = 4'(count - 5'd1);
  assign sec_idx = 4'(count - 5'd2);

  // done rises on the DONE->IDLE edge and is high for the first IDLE
  // cycle; that cycle is a turnaround, so req is only taken once done
  // has dropped again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 5'd0;
      tos    <= 8'h00;
      nos    <= 8'h00;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      err_q  <= 1'b0;
      op_q   <= 2'b00;
      data_q <= 8'h00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && !done) begin
            op_q   <= op;
            data_q <= push_data;
            err_q  <= 1'b0;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          state <= DONE;
          unique case (op_q)
            OP_PUSH: begin
              if (full) begin
                err_q <= 1'b1;
              end else begin
                mem[count[3:0]] <= data_q;
                count <= count + 5'd1;
              end
            end
            OP_POP: begin
              if (empty) begin
                err_q <= 1'b1;
              end else begin
                tos   <= mem[top_idx];
                count <= count - 5'd1;
              end
            end
            OP_PEEK: begin
              if (empty) err_q <= 1'b1;
              else       tos   <= mem[top_idx];
            end
            OP_POP2: begin
              // atomic: nothing moves unless both entries exist
              if (count < 5'd2) begin
                err_q <= 1'b1;
              end else begin
                tos   <= mem[top_idx];
                state <= EXEC2;
              end
            end
            default: ;
          endcase
        end
        EXEC2: begin
          nos   <= mem[sec_idx];
          count <= count - 5'd2;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          err   <= err_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed testbench for stack_ctrl.
// Each scenario task drives stimulus and checks results inline.
module tb_stack_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic [1:0] op;
  logic [7:0] push_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] tos;
  logic [7:0] nos;
  logic [4:0] count;
  logic       empty;
  logic       full;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] POP2 = 2'b10;
  localparam logic [1:0] PEEK = 2'b11;

  stack_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op        (op),
    .push_data (push_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request; lat = edges from accept edge until done seen.
  task automatic run_op(input logic [1:0] o, input logic [7:0] d,
                        output int lat, output logic e);
    req = 1'b1;
    op = o;
    push_data = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    e = err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (count !== 5'd0) begin
      $display("FAIL rst_count got=%0d exp=0", count); bad++;
    end
    total++;
    if ({busy, done, err} !== 3'b000) begin
      $display("FAIL rst_flags got=%b exp=000", {busy, done, err}); bad++;
    end
    total++;
    if ({tos, nos} !== 16'h0000) begin
      $display("FAIL rst_tos_nos got=%h exp=0000", {tos, nos}); bad++;
    end
    total++;
    if ({empty, full} !== 2'b10) begin
      $display("FAIL rst_empty_full got=%b exp=10", {empty, full}); bad++;
    end
  endtask

  task automatic test_push_pop();
    int lat;
    logic e;
    do_reset();
    run_op(PUSH, 8'h12, lat, e);
    total++;
    if (lat !== 2 || e !== 1'b0) begin
      $display("FAIL pp_push1 got lat=%0d err=%b exp lat=2 err=0", lat, e); bad++;
    end
    run_op(PUSH, 8'h34, lat, e);
    total++;
    if (lat !== 2 || count !== 5'd2) begin
      $display("FAIL pp_push2 got lat=%0d cnt=%0d exp 2/2", lat, count); bad++;
    end
    run_op(POP, 8'h00, lat, e);
    total++;
    if (lat !== 2 || e !== 1'b0 || tos !== 8'h34 || count !== 5'd1) begin
      $display("FAIL pp_pop got lat=%0d err=%b tos=%h cnt=%0d exp 2/0/34/1",
               lat, e, tos, count); bad++;
    end
  endtask

  task automatic test_pop2();
    int lat;
    logic e;
    do_reset();
    run_op(PUSH, 8'h05, lat, e);
    run_op(PUSH, 8'h07, lat, e);
    run_op(POP2, 8'h00, lat, e);
    total++;
    if (lat !== 3 || e !== 1'b0) begin
      $display("FAIL pop2_lat got lat=%0d err=%b exp 3/0", lat, e); bad++;
    end
    total++;
    if (tos !== 8'h07 || nos !== 8'h05 || count !== 5'd0) begin
      $display("FAIL pop2_data got tos=%h nos=%h cnt=%0d exp 07/05/0",
               tos, nos, count); bad++;
    end
  endtask

  task automatic test_full();
    int lat;
    logic e;
    do_reset();
    for (int i = 0; i < 16; i++) run_op(PUSH, 8'(i), lat, e);
    total++;
    if (full !== 1'b1 || empty !== 1'b0 || count !== 5'd16) begin
      $display("FAIL full_flag got full=%b cnt=%0d exp 1/16", full, count); bad++;
    end
    run_op(PUSH, 8'hFF, lat, e);
    total++;
    if (e !== 1'b1 || lat !== 2 || count !== 5'd16) begin
      $display("FAIL full_ovf got err=%b lat=%0d cnt=%0d exp 1/2/16",
               e, lat, count); bad++;
    end
    run_op(PEEK, 8'h00, lat, e);
    total++;
    if (tos !== 8'h0F || e !== 1'b0 || count !== 5'd16) begin
      $display("FAIL full_peek got tos=%h err=%b cnt=%0d exp 0f/0/16",
               tos, e, count); bad++;
    end
  endtask

  task automatic test_underflow();
    int lat;
    logic e;
    do_reset();
    run_op(POP, 8'h00, lat, e);
    total++;
    if (e !== 1'b1 || tos !== 8'h00 || count !== 5'd0) begin
      $display("FAIL uf_pop got err=%b tos=%h cnt=%0d exp 1/00/0", e, tos, count); bad++;
    end
    total++;
    if (err !== 1'b0) begin
      $display("FAIL uf_err_idle got=%b exp=0", err); bad++;
    end
    run_op(PUSH, 8'hAA, lat, e);
    run_op(POP2, 8'h00, lat, e);
    total++;
    if (e !== 1'b1 || lat !== 2 || count !== 5'd1 || tos !== 8'h00) begin
      $display("FAIL uf_pop2 got err=%b lat=%0d cnt=%0d tos=%h exp 1/2/1/00",
               e, lat, count, tos); bad++;
    end
    run_op(PEEK, 8'h00, lat, e);
    total++;
    if (e !== 1'b0 || tos !== 8'hAA || count !== 5'd1) begin
      $display("FAIL uf_peek got err=%b tos=%h cnt=%0d exp 0/aa/1", e, tos, count); bad++;
    end
    run_op(POP, 8'h00, lat, e);
    total++;
    if (e !== 1'b0 || tos !== 8'hAA || count !== 5'd0) begin
      $display("FAIL uf_pop_last got err=%b tos=%h cnt=%0d exp 0/aa/0", e, tos, count); bad++;
    end
  endtask

  task automatic test_latch();
    int lat;
    logic e;
    do_reset();
    req = 1'b1;
    op = PUSH;
    push_data = 8'h11;
    @(posedge clk); #1;
    req = 1'b0;
    op = POP;
    push_data = 8'h99;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (count !== 5'd1) begin
      $display("FAIL latch_cnt got=%0d exp=1", count); bad++;
    end
    run_op(POP, 8'h00, lat, e);
    total++;
    if (tos !== 8'h11) begin
      $display("FAIL latch_data got=%h exp=11", tos); bad++;
    end
  endtask

  task automatic test_req_hold();
    int lat;
    logic e;
    do_reset();
    req = 1'b1;
    op = PUSH;
    push_data = 8'h55;
    repeat (8) @(posedge clk);
    #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (count !== 5'd2) begin
      $display("FAIL hold_count got=%0d exp=2", count); bad++;
    end
    run_op(PEEK, 8'h00, lat, e);
    total++;
    if (tos !== 8'h55 || e !== 1'b0) begin
      $display("FAIL hold_peek got tos=%h err=%b exp 55/0", tos, e); bad++;
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic e;
    logic seen;
    do_reset();
    run_op(PUSH, 8'h01, lat, e);
    run_op(PUSH, 8'h02, lat, e);
    run_op(PUSH, 8'h03, lat, e);
    req = 1'b1;
    op = POP2;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || tos !== 8'h03) begin
      $display("FAIL mid_exec2 got busy=%b tos=%h exp 1/03", busy, tos); bad++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (count !== 5'd0 || tos !== 8'h00 || nos !== 8'h00) begin
      $display("FAIL mid_rst_state got cnt=%0d tos=%h nos=%h exp 0/00/00",
               count, tos, nos); bad++;
    end
    total++;
    if ({busy, done, err} !== 3'b000) begin
      $display("FAIL mid_rst_flags got=%b exp=000", {busy, done, err}); bad++;
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || count !== 5'd0) begin
      $display("FAIL mid_no_done got seen=%b cnt=%0d exp 0/0", seen, count); bad++;
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0;
    op = 2'b00;
    push_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_push_pop();
    test_pop2();
    test_full();
    test_underflow();
    test_latch();
    test_req_hold();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
